// File: rtl/instrom_arb_pkg.sv
// Shared definitions for the instruction-ROM read-port arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t  - arbiter state (PRIO0: fetch has priority, FORCE1: aux has priority)
//   P_FETCH/P_AUX - port indices into per-port vectors
//   ALIGN_MASK   - byte-offset bits that must be zero for a word-aligned address
//   is_misaligned() - flags a request whose low address bits are non-zero
package instrom_arb_pkg;

  typedef enum logic {
    PRIO0  = 1'b0,
    FORCE1 = 1'b1
  } arb_state_t;

  localparam int P_FETCH = 0;
  localparam int P_AUX   = 1;

  // Width of the burst counter; MAX_BURST is limited to 1..15 so 4 bits suffice.
  localparam int CNT_W = 4;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return |(addr_lo & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/instrom_resp_buf.sv
// One-entry valid/ready response register holding a ROM word and its error flag.
// Latency: load -> valid on the next clk edge (1 cycle).
// Backpressure: holds data/err while valid && !ready; a load in the same cycle as a drain reloads.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   load, load_data, load_err - capture a new response at the next edge
//   ready              - consumer takes the buffered response this cycle
//   valid, data, err   - buffered response
module instrom_resp_buf
  import instrom_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_err,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  // The arbiter only loads a buffer that is empty or draining this cycle,
  // so a load always wins over a drain and no response is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      err   <= load_err;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instrom_arbiter.sv
// Shares the single instrom read port between fetch (port 0) and an aux reader (port 1).
// Latency: combinational grant/ROM access; response buffered 1 cycle after request accept.
// Backpressure: a port whose response buffer is full and not draining is skipped for that cycle.
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   pN_req_valid/addr/ready        - request handshake for port N (byte address)
//   pN_resp_valid/data/err/ready   - response handshake for port N (err = misaligned address)
//   rom_ren, rom_addr, rom_data    - ROM read port; rom_data is combinational from rom_addr
module instrom_arbiter
  import instrom_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req_valid,
  input  logic [ADDR_W-1:0] p0_req_addr,
  output logic              p0_req_ready,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_resp_data,
  output logic              p0_resp_err,
  input  logic              p0_resp_ready,

  input  logic              p1_req_valid,
  input  logic [ADDR_W-1:0] p1_req_addr,
  output logic              p1_req_ready,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_resp_data,
  output logic              p1_resp_err,
  input  logic              p1_resp_ready,

  output logic              rom_ren,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);

  arb_state_t        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] aligned_addr;
  logic [ADDR_W-1:0] last_addr_q;

  // A full buffer that drains this cycle counts as free, which is what
  // gives each port back-to-back throughput of one response per cycle.
  assign elig[P_FETCH] = p0_req_valid && (!p0_resp_valid || p0_resp_ready);
  assign elig[P_AUX]   = p1_req_valid && (!p1_resp_valid || p1_resp_ready);

  // Grant and next-state logic. Nothing is granted while reset is held so the
  // ROM port stays idle and no buffer is loaded during reset.
  always_comb begin
    gnt     = '0;
    state_n = state_q;
    cnt_n   = cnt_q;

    if (!rst) begin
      if (state_q == FORCE1) begin
        if (elig[P_AUX])        gnt[P_AUX]   = 1'b1;
        else if (elig[P_FETCH]) gnt[P_FETCH] = 1'b1;
      end else begin
        if (elig[P_FETCH])      gnt[P_FETCH] = 1'b1;
        else if (elig[P_AUX])   gnt[P_AUX]   = 1'b1;
      end
    end

    // The counter measures how long port 1 has been waiting behind fetch.
    // It saturates at MAX_B so a port-1 buffer stalled in FORCE1 (fetch
    // granted as fallback) keeps the FSM forced until port 1 is served.
    if (gnt[P_AUX] || !p1_req_valid) begin
      cnt_n   = '0;
      state_n = PRIO0;
    end else if (gnt[P_FETCH]) begin
      if (cnt_q < MAX_B) cnt_n = cnt_q + CNT_W'(1);
      if (cnt_n == MAX_B) state_n = FORCE1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIO0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  assign sel_addr     = gnt[P_AUX] ? p1_req_addr : p0_req_addr;
  assign aligned_addr = {sel_addr[ADDR_W-1:2], 2'b00};

  assign p0_req_ready = gnt[P_FETCH];
  assign p1_req_ready = gnt[P_AUX];
  assign rom_ren      = |gnt;

  // rom_addr parks on the last granted address so the ROM address bus does
  // not toggle on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr_q <= '0;
    end else if (rom_ren) begin
      last_addr_q <= aligned_addr;
    end
  end

  assign rom_addr = rst ? '0 : (rom_ren ? aligned_addr : last_addr_q);

  instrom_resp_buf #(.DATA_W(DATA_W)) u_buf_fetch (
    .clk       (clk),
    .rst       (rst),
    .load      (gnt[P_FETCH]),
    .load_data (rom_data),
    .load_err  (is_misaligned(p0_req_addr[1:0])),
    .ready     (p0_resp_ready),
    .valid     (p0_resp_valid),
    .data      (p0_resp_data),
    .err       (p0_resp_err)
  );

  instrom_resp_buf #(.DATA_W(DATA_W)) u_buf_aux (
    .clk       (clk),
    .rst       (rst),
    .load      (gnt[P_AUX]),
    .load_data (rom_data),
    .load_err  (is_misaligned(p1_req_addr[1:0])),
    .ready     (p1_resp_ready),
    .valid     (p1_resp_valid),
    .data      (p1_resp_data),
    .err       (p1_resp_err)
  );

endmodule

// File: tb/tb_instrom_arbiter.sv
// Testbench for instrom_arbiter: directed scenarios plus random traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_instrom_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_resp_valid, p0_resp_err, p0_resp_ready;
  logic [31:0] p0_req_addr, p0_resp_data;
  logic        p1_req_valid, p1_req_ready, p1_resp_valid, p1_resp_err, p1_resp_ready;
  logic [31:0] p1_req_addr, p1_resp_data;
  logic        rom_ren;
  logic [31:0] rom_addr, rom_data;

  int errors = 0;
  int checks = 0;
  int g;

  // Reference state: what each response buffer should hold, where the ROM
  // address bus should rest, and how many fetch grants port 1 has waited through.
  logic        m_vld [2];
  logic [31:0] m_dat [2];
  logic        m_err [2];
  logic [31:0] m_last;
  int          m_streak;

  instrom_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
    .clk           (clk),
    .rst           (rst),
    .p0_req_valid  (p0_req_valid),
    .p0_req_addr   (p0_req_addr),
    .p0_req_ready  (p0_req_ready),
    .p0_resp_valid (p0_resp_valid),
    .p0_resp_data  (p0_resp_data),
    .p0_resp_err   (p0_resp_err),
    .p0_resp_ready (p0_resp_ready),
    .p1_req_valid  (p1_req_valid),
    .p1_req_addr   (p1_req_addr),
    .p1_req_ready  (p1_req_ready),
    .p1_resp_valid (p1_resp_valid),
    .p1_resp_data  (p1_resp_data),
    .p1_resp_err   (p1_resp_err),
    .p1_resp_ready (p1_resp_ready),
    .rom_ren       (rom_ren),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign rom_data = rom_word(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check every output
  // against the model, then advance the model to the state after the next rising edge.
  task automatic step(input logic r,
                      input logic v0, input logic [31:0] a0, input logic rr0,
                      input logic v1, input logic [31:0] a1, input logic rr1,
                      output int gnt);
    logic        e0, e1;
    logic [31:0] aa, ea;
    @(negedge clk);
    rst = r;
    p0_req_valid = v0; p0_req_addr = a0; p0_resp_ready = rr0;
    p1_req_valid = v1; p1_req_addr = a1; p1_resp_ready = rr1;
    #1;
    gnt = -1;
    if (!r) begin
      e0 = v0 && (!m_vld[0] || rr0);
      e1 = v1 && (!m_vld[1] || rr1);
      if (e1 && (m_streak >= MAX_BURST || !e0)) gnt = 1;
      else if (e0) gnt = 0;
    end
    aa = ((gnt == 1) ? a1 : a0) & ~32'h3;
    ea = r ? 32'h0 : ((gnt >= 0) ? aa : m_last);

    chk("p0_req_ready",  32'(p0_req_ready),  32'(gnt == 0));
    chk("p1_req_ready",  32'(p1_req_ready),  32'(gnt == 1));
    chk("rom_ren",       32'(rom_ren),       32'(gnt >= 0));
    chk("rom_addr",      rom_addr,           ea);
    chk("p0_resp_valid", 32'(p0_resp_valid), 32'(m_vld[0]));
    chk("p0_resp_data",  p0_resp_data,       m_dat[0]);
    chk("p0_resp_err",   32'(p0_resp_err),   32'(m_err[0]));
    chk("p1_resp_valid", 32'(p1_resp_valid), 32'(m_vld[1]));
    chk("p1_resp_data",  p1_resp_data,       m_dat[1]);
    chk("p1_resp_err",   32'(p1_resp_err),   32'(m_err[1]));

    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_vld[i] = 1'b0; m_dat[i] = 32'h0; m_err[i] = 1'b0;
      end
      m_last = 32'h0;
      m_streak = 0;
    end else begin
      if (gnt == 0) begin
        m_vld[0] = 1'b1; m_dat[0] = rom_word(aa); m_err[0] = (a0[1:0] != 2'b00);
      end else if (rr0) begin
        m_vld[0] = 1'b0;
      end
      if (gnt == 1) begin
        m_vld[1] = 1'b1; m_dat[1] = rom_word(aa); m_err[1] = (a1[1:0] != 2'b00);
      end else if (rr1) begin
        m_vld[1] = 1'b0;
      end
      if (gnt >= 0) m_last = aa;
      if (gnt == 1 || !v1) m_streak = 0;
      else if (gnt == 0) m_streak++;
    end
  endtask

  task automatic idle();
    int gi;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, gi);
  endtask

  initial begin
    int pat0 [10];
    int pat1 [5];

    rst = 1'b1;
    p0_req_valid = 1'b0; p0_req_addr = 32'h0; p0_resp_ready = 1'b1;
    p1_req_valid = 1'b0; p1_req_addr = 32'h0; p1_resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 1'b0; m_dat[i] = 32'h0; m_err[i] = 1'b0;
    end
    m_last = 32'h0;
    m_streak = 0;
    @(posedge clk);
    @(posedge clk);

    // Reset state (outputs checked by the model while rst is held).
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, g);
    chk("reset_rom_ren", 32'(rom_ren), 32'h0);
    chk("reset_rom_addr", rom_addr, 32'h0);

    // Single fetch at 0x10.
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1, g);
    chk("t1_rom_addr", rom_addr, 32'h10);
    chk("t1_p0_req_ready", 32'(p0_req_ready), 32'h1);
    idle();
    chk("t1_resp_valid", 32'(p0_resp_valid), 32'h1);
    chk("t1_resp_data", p0_resp_data, rom_word(32'h10));
    chk("t1_resp_err", 32'(p0_resp_err), 32'h0);

    // Both ports continuously requesting: port 1 served every MAX_BURST+1 cycles.
    idle();
    pat0 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b1, 32'h200 + 32'(4 * i), 1'b1, g);
      chk($sformatf("t2_grant_%0d", i), 32'(g), 32'(pat0[i]));
      chk($sformatf("t2_p1_ready_%0d", i), 32'(p1_req_ready), 32'(pat0[i] == 1));
    end

    // Fetch buffer stalled: port 1 gets every slot, fetch data holds.
    idle();
    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b1, g);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h24, 1'b0, 1'b1, 32'h40 + 32'(4 * i), 1'b1, g);
      chk($sformatf("t3_p1_ready_%0d", i), 32'(p1_req_ready), 32'h1);
      chk($sformatf("t3_p0_hold_%0d", i), p0_resp_data, rom_word(32'h20));
    end
    idle();

    // Misaligned aux request.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6, 1'b1, g);
    chk("t4_rom_addr", rom_addr, 32'h4);
    idle();
    chk("t4_p1_err", 32'(p1_resp_err), 32'h1);
    chk("t4_p1_data", p1_resp_data, rom_word(32'h4));

    // Streaming fetch with no bubbles.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i < 4), 32'(4 * i), 1'b1, 1'b0, 32'h0, 1'b1, g);
      if (i > 0) begin
        chk($sformatf("t5_valid_%0d", i), 32'(p0_resp_valid), 32'h1);
        chk($sformatf("t5_data_%0d", i), p0_resp_data, rom_word(32'(4 * (i - 1))));
      end
    end

    // Reset while forced toward port 1 with a response pending.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h90, 1'b1, g);
    chk("t6_pre_p0_valid", 32'(p0_resp_valid), 32'h1);
    step(1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h90, 1'b1, g);
    pat1 = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h90, 1'b1, g);
      if (i == 0) chk("t6_p0_valid_cleared", 32'(p0_resp_valid), 32'h0);
      chk($sformatf("t6_grant_%0d", i), 32'(g), 32'(pat1[i]));
    end

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7), 32'($urandom_range(0, 255)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 7), 32'($urandom_range(0, 255)), ($urandom_range(0, 9) < 6),
           g);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instrom_arbiter.md
Name: instrom_arbiter

Overview:
Shares the single read port of `instrom` between two requesters.
- Port 0: `openmips` instruction fetch.
- Port 1: a secondary reader, such as a debug/loader or data-side literal fetch.
- The block sits between `openmips` and `instrom` in `top`. It drives `openmips_instrom_ren` and `openmips_instrom_addr`, and registers `instrom_openmips_data` into a one-entry response buffer per port.
- Arbitration is fetch-priority with a starvation guard for port 1.

Parameters:
- ADDR_W, 32, request/ROM address width
- DATA_W, 32, instruction word width
- MAX_BURST, 4, max consecutive port-0 grants while port 1 is waiting (range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- p0_req_valid  in  1  fetch request
- p0_req_addr  in  ADDR_W  fetch byte address
- p0_req_ready  out  1  fetch request accepted this cycle
- p0_resp_valid  out  1  fetch response buffered
- p0_resp_data  out  DATA_W  fetched word
- p0_resp_err  out  1  address was misaligned (addr[1:0]!=0)
- p0_resp_ready  in  1  fetch consumer takes response
- p1_req_valid, p1_req_addr, p1_req_ready, p1_resp_valid, p1_resp_data, p1_resp_err, p1_resp_ready: same as port 0, for the secondary port
- rom_ren  out  1  ROM read enable (to `openmips_instrom_ren` input of `instrom`)
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DATA_W  ROM read data; combinational in the same cycle as rom_addr

Behaviour:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - all resp_valid, resp_err = 0; resp_data = 0.
  - rom_ren = 0, rom_addr = 0.
  - burst counter = 0; FSM = PRIO0.
- Eligibility: port n is eligible when `pn_req_valid` && (!`pn_resp_valid` || `pn_resp_ready`). A full buffer draining in the same cycle counts as free.
- FSM:
  - PRIO0: grant port 0 if eligible, else port 1 if eligible.
  - FORCE1: grant port 1 if eligible, else port 0.
- Burst counter:
  - increments on each port-0 grant while `p1_req_valid`=1.
  - clears on any port-1 grant, or when `p1_req_valid`=0.
  - when it reaches MAX_BURST, the FSM enters FORCE1.
  - a port-1 grant returns the FSM to PRIO0 and clears the counter.
- Grant is combinational, at most one per cycle:
  - `pn_req_ready`=1 for the granted port only.
  - `rom_ren`=1 and `rom_addr`={req_addr[ADDR_W-1:2],2'b00} from the granted port.
  - `rom_ren`=0 and `rom_addr` holds its last value when there is no grant.
- Response:
  - on grant, at the next clk edge: resp_data <= rom_data, resp_err <= (addr[1:0]!=0), resp_valid <= 1.
  - latency: request accept -> resp_valid exactly 1 cycle.
  - resp_valid clears on resp_ready unless a new grant to the same port reloads it that cycle (back-to-back throughput of 1/cycle per port).
- Response hold: resp_data/err are stable while resp_valid && !resp_ready.
- Misaligned requests: still consume a ROM slot; data = word at the aligned address; err=1.
- Simultaneous grant + drain on one port: the buffer reloads with the new word and never drops a response.
- Reset mid-operation: pending responses are discarded; the requester must re-issue.
- Buffer backpressure: a port with a full, non-draining buffer is skipped; the other port is granted instead, with no idle ROM cycle.

Decomposition:
- Shared package `instrom_arb_pkg`:
  - FSM state encoding (PRIO0=1'b0, FORCE1=1'b1)
  - port index constants P_FETCH=0, P_AUX=1
  - alignment mask constant
- One natural sub-module: `instrom_resp_buf`, the one-entry valid/ready response register with data and err. It is instantiated twice.

Test Plan:
1. Reset, then p0 fetch at 0x0000_0010 with resp_ready=1 -> rom_ren=1, rom_addr=0x10, p0_req_ready=1 in the same cycle; next cycle p0_resp_valid=1, data=ROM[4], err=0.
2. p0 and p1 both continuously valid, MAX_BURST=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1…; port 1 is never starved beyond 4 cycles.
3. p0_resp_ready=0 after one fetch, both ports requesting -> p0 is skipped; p1 is granted every cycle; p0_resp_data holds its value.
4. p1 request at address 0x0000_0006 -> rom_addr=0x04; p1_resp_err=1; data=ROM[1].
5. p0 streaming with resp_ready=1 and sequential addresses 0,4,8,C -> four responses on four consecutive cycles, with no bubbles.
6. Assert rst while p0_resp_valid=1 and FSM=FORCE1 -> next cycle all resp_valid=0, rom_ren=0, FSM=PRIO0, counter=0.
